// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
// Opcode/func constants follow the standard MIPS32 encoding.
package mc_pkg;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StTrap   = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      ClsNone,
      ClsRAlu,
      ClsImm,
      ClsLw,
      ClsLb,
      ClsSw,
      ClsSb,
      ClsBranch,
      ClsMulDiv,
      ClsJ,
      ClsJal,
      ClsSyscall,
      ClsIllegal
   } cls_e;

   localparam int unsigned AluW = 6;

   // Opcodes (IR[31:26]); REGIMM is only used for BGEZ here
   localparam logic [5:0] OpRType  = 6'b000000;
   localparam logic [5:0] OpRegImm = 6'b000001;
   localparam logic [5:0] OpJ      = 6'b000010;
   localparam logic [5:0] OpJal    = 6'b000011;
   localparam logic [5:0] OpBeq    = 6'b000100;
   localparam logic [5:0] OpBne    = 6'b000101;
   localparam logic [5:0] OpBlez   = 6'b000110;
   localparam logic [5:0] OpBgtz   = 6'b000111;
   localparam logic [5:0] OpAddi   = 6'b001000;
   localparam logic [5:0] OpAddiu  = 6'b001001;
   localparam logic [5:0] OpSlti   = 6'b001010;
   localparam logic [5:0] OpAndi   = 6'b001100;
   localparam logic [5:0] OpOri    = 6'b001101;
   localparam logic [5:0] OpXori   = 6'b001110;
   localparam logic [5:0] OpLui    = 6'b001111;
   localparam logic [5:0] OpLb     = 6'b100000;
   localparam logic [5:0] OpLw     = 6'b100011;
   localparam logic [5:0] OpSb     = 6'b101000;
   localparam logic [5:0] OpSw     = 6'b101011;

   // R-type func codes; the ALU ones double as the alu_op encoding
   localparam logic [AluW-1:0] FnAdd     = 6'b100000;
   localparam logic [AluW-1:0] FnAddu    = 6'b100001;
   localparam logic [AluW-1:0] FnSub     = 6'b100010;
   localparam logic [AluW-1:0] FnAnd     = 6'b100100;
   localparam logic [AluW-1:0] FnOr      = 6'b100101;
   localparam logic [AluW-1:0] FnXor     = 6'b100110;
   localparam logic [AluW-1:0] FnSlt     = 6'b101010;
   localparam logic [AluW-1:0] FnSyscall = 6'b001100;
   localparam logic [AluW-1:0] FnMult    = 6'b011000;
   localparam logic [AluW-1:0] FnDiv     = 6'b011010;

   localparam logic [1:0] PcSrcPlus4  = 2'd0;
   localparam logic [1:0] PcSrcBranch = 2'd1;
   localparam logic [1:0] PcSrcJump   = 2'd2;

   localparam logic [1:0] RegDstRt  = 2'd0;
   localparam logic [1:0] RegDstRd  = 2'd1;
   localparam logic [1:0] RegDstR31 = 2'd2;

   localparam logic [1:0] WbSelAlu = 2'd0;
   localparam logic [1:0] WbSelMem = 2'd1;
   localparam logic [1:0] WbSelPc4 = 2'd2;

   localparam logic [1:0] CauseNone    = 2'd0;
   localparam logic [1:0] CauseIllegal = 2'd1;
   localparam logic [1:0] CauseSyscall = 2'd2;
   localparam logic [1:0] CauseTimeout = 2'd3;

   function automatic logic is_load(cls_e c);
      return (c == ClsLw) || (c == ClsLb);
   endfunction

   function automatic logic is_store(cls_e c);
      return (c == ClsSw) || (c == ClsSb);
   endfunction

   function automatic logic is_byte(cls_e c);
      return (c == ClsLb) || (c == ClsSb);
   endfunction

endpackage

// File: rtl/mc_control_decode.sv
// Combinational instruction classifier: opcode/func -> class, ALU function and operand select.
// Unknown R-type funcs are classed illegal alongside unknown opcodes.
module mc_decode
   import mc_pkg::*;
#(
   parameter bit MULDIV_EN = 1'b1
) (
   input  logic [5:0]      opcode,
   input  logic [5:0]      func,
   output cls_e            cls,
   output logic [AluW-1:0] alu_op,
   output logic            alu_src,
   output logic            illegal,
   output logic            syscall
);

   always_comb begin
      cls     = ClsIllegal;
      alu_op  = FnAdd;
      alu_src = 1'b0;
      case (opcode)
         OpRType: begin
            alu_op = func;
            case (func)
               FnAdd, FnAddu, FnSub, FnAnd, FnOr, FnXor, FnSlt: cls = ClsRAlu;
               FnMult, FnDiv: cls = MULDIV_EN ? ClsMulDiv : ClsIllegal;
               FnSyscall:     cls = ClsSyscall;
               default:       cls = ClsIllegal;
            endcase
         end
         OpJ:   cls = ClsJ;
         OpJal: cls = ClsJal;
         OpBeq, OpBne, OpBlez, OpBgtz, OpRegImm: begin
            cls    = ClsBranch;
            alu_op = FnSub;
         end
         OpAddi: begin
            cls     = ClsImm;
            alu_src = 1'b1;
         end
         OpAddiu: begin
            cls     = ClsImm;
            alu_op  = FnAddu;
            alu_src = 1'b1;
         end
         OpSlti: begin
            cls     = ClsImm;
            alu_op  = FnSlt;
            alu_src = 1'b1;
         end
         OpAndi: begin
            cls     = ClsImm;
            alu_op  = FnAnd;
            alu_src = 1'b1;
         end
         OpOri: begin
            cls     = ClsImm;
            alu_op  = FnOr;
            alu_src = 1'b1;
         end
         OpXori: begin
            cls     = ClsImm;
            alu_op  = FnXor;
            alu_src = 1'b1;
         end
         // LUI adds the upper-immediate operand to zero in the datapath
         OpLui: begin
            cls     = ClsImm;
            alu_src = 1'b1;
         end
         OpLw: begin
            cls     = ClsLw;
            alu_src = 1'b1;
         end
         OpLb: begin
            cls     = ClsLb;
            alu_src = 1'b1;
         end
         OpSw: begin
            cls     = ClsSw;
            alu_src = 1'b1;
         end
         OpSb: begin
            cls     = ClsSb;
            alu_src = 1'b1;
         end
         default: cls = ClsIllegal;
      endcase
   end

   assign illegal = (cls == ClsIllegal);
   assign syscall = (cls == ClsSyscall);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory and MULT/DIV stalls,
// plus a sticky trap for illegal opcodes, syscall and memory timeout.
module mc_control
   import mc_pkg::*;
#(
   parameter int unsigned ALU_OP_W  = 6,
   parameter int unsigned TIMEOUT   = 16,
   parameter bit          MULDIV_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          opcode,
   input  logic [5:0]          func,
   input  logic                mem_ready,
   input  logic                alu_done,
   input  logic                cond_true,
   output logic                ir_write,
   output logic                pc_write,
   output logic [1:0]          pc_src,
   output logic                mem_req,
   output logic                mem_we,
   output logic                mem_byte,
   output logic                iord,
   output logic                reg_write,
   output logic [1:0]          reg_dst,
   output logic [1:0]          wb_sel,
   output logic                alu_src,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                alu_start,
   output logic                retire,
   output logic                trap,
   output logic [1:0]          trap_cause,
   output logic [2:0]          state
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e          state_q, state_d;
   cls_e            cls_q;
   logic [AluW-1:0] alu_op_q;
   logic            alu_src_q;
   logic [1:0]      cause_q, cause_d;
   logic            started_q, started_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            expired;
   logic [AluW-1:0] alu_op_c;

   cls_e            dec_cls;
   logic [AluW-1:0] dec_alu_op;
   logic            dec_alu_src;
   logic            dec_illegal;
   logic            dec_syscall;

   mc_decode #(
      .MULDIV_EN (MULDIV_EN)
   ) u_decode (
      .opcode  (opcode),
      .func    (func),
      .cls     (dec_cls),
      .alu_op  (dec_alu_op),
      .alu_src (dec_alu_src),
      .illegal (dec_illegal),
      .syscall (dec_syscall)
   );

   // Last allowed wait cycle; a mem_ready arriving here still completes the access
   assign expired = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

   always_comb begin
      state_d   = state_q;
      cause_d   = cause_q;
      started_d = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PcSrcPlus4;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_byte  = 1'b0;
      iord      = 1'b0;
      reg_write = 1'b0;
      reg_dst   = RegDstRt;
      wb_sel    = WbSelAlu;
      alu_src   = 1'b0;
      alu_op_c  = '0;
      alu_start = 1'b0;
      retire    = 1'b0;

      unique case (state_q)
         StFetch: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = StDecode;
            end else if (expired) begin
               state_d = StTrap;
               cause_d = CauseTimeout;
            end
         end
         StDecode: begin
            if (dec_illegal) begin
               state_d = StTrap;
               cause_d = CauseIllegal;
            end else if (dec_syscall) begin
               state_d = StTrap;
               cause_d = CauseSyscall;
            end else if (dec_cls == ClsJ || dec_cls == ClsJal) begin
               pc_write = 1'b1;
               pc_src   = PcSrcJump;
               retire   = 1'b1;
               state_d  = StFetch;
               if (dec_cls == ClsJal) begin
                  reg_write = 1'b1;
                  reg_dst   = RegDstR31;
                  wb_sel    = WbSelPc4;
               end
            end else begin
               state_d = StExec;
            end
         end
         StExec: begin
            alu_op_c = alu_op_q;
            alu_src  = alu_src_q;
            case (cls_q)
               ClsMulDiv: begin
                  alu_start = !started_q;
                  started_d = 1'b1;
                  if (alu_done) begin
                     retire    = 1'b1;
                     started_d = 1'b0;
                     state_d   = StFetch;
                  end
               end
               ClsBranch: begin
                  pc_src   = PcSrcBranch;
                  pc_write = cond_true;
                  retire   = 1'b1;
                  state_d  = StFetch;
               end
               ClsLw, ClsLb, ClsSw, ClsSb: state_d = StMem;
               default:                    state_d = StWb;
            endcase
         end
         StMem: begin
            alu_op_c = alu_op_q;
            alu_src  = alu_src_q;
            mem_req  = 1'b1;
            iord     = 1'b1;
            mem_we   = is_store(cls_q);
            mem_byte = is_byte(cls_q);
            if (mem_ready) begin
               if (is_store(cls_q)) begin
                  retire  = 1'b1;
                  state_d = StFetch;
               end else begin
                  state_d = StWb;
               end
            end else if (expired) begin
               state_d = StTrap;
               cause_d = CauseTimeout;
            end
         end
         StWb: begin
            alu_op_c  = alu_op_q;
            alu_src   = alu_src_q;
            reg_write = 1'b1;
            reg_dst   = (cls_q == ClsRAlu) ? RegDstRd : RegDstRt;
            wb_sel    = is_load(cls_q) ? WbSelMem : WbSelAlu;
            retire    = 1'b1;
            state_d   = StFetch;
         end
         StTrap: begin
            state_d = StTrap;
         end
         default: begin
            state_d = StFetch;
         end
      endcase

      // Counter restarts on every entry to a memory-wait state
      cnt_d = '0;
      if ((state_q == StFetch || state_q == StMem) && !mem_ready && state_d == state_q) begin
         cnt_d = cnt_q + 1'b1;
      end

      // Holding reset must silence the datapath even though state is already FETCH
      if (!rst_n) begin
         ir_write  = 1'b0;
         pc_write  = 1'b0;
         pc_src    = PcSrcPlus4;
         mem_req   = 1'b0;
         mem_we    = 1'b0;
         mem_byte  = 1'b0;
         iord      = 1'b0;
         reg_write = 1'b0;
         reg_dst   = RegDstRt;
         wb_sel    = WbSelAlu;
         alu_src   = 1'b0;
         alu_op_c  = '0;
         alu_start = 1'b0;
         retire    = 1'b0;
      end
   end

   assign alu_op     = ALU_OP_W'(alu_op_c);
   assign trap       = (state_q == StTrap);
   assign trap_cause = cause_q;
   assign state      = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StFetch;
         cause_q   <= CauseNone;
         started_q <= 1'b0;
         cnt_q     <= '0;
         cls_q     <= ClsNone;
         alu_op_q  <= '0;
         alu_src_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cause_q   <= cause_d;
         started_q <= started_d;
         cnt_q     <= cnt_d;
         if (state_q == StDecode) begin
            cls_q     <= dec_cls;
            alu_op_q  <= dec_alu_op;
            alu_src_q <= dec_alu_src;
         end
      end
   end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: latency table, directed corner sequences and
// randomized instruction streams against a per-instruction phase model.
module tb_mc_control;

   localparam int unsigned TIMEOUT = 16;

   typedef struct packed {
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       mem_req;
      logic       mem_we;
      logic       mem_byte;
      logic       iord;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] wb_sel;
      logic       alu_src;
      logic [5:0] alu_op;
      logic       alu_start;
      logic       retire;
      logic       trap;
      logic [1:0] trap_cause;
      logic [2:0] state;
   } outs_t;

   typedef enum int {KAlu, KImm, KLw, KLb, KSw, KSb, KBr, KMd, KJ, KJal, KSys, KIll} kind_e;

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      logic       cond;
      int         cycles;
      int         regw;
      logic [1:0] cause;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [5:0] opcode = '0;
   logic [5:0] func = '0;
   logic       mem_ready = 1'b0;
   logic       alu_done = 1'b0;
   logic       cond_true = 1'b0;
   logic       ir_write, pc_write, mem_req, mem_we, mem_byte, iord, reg_write;
   logic [1:0] pc_src, reg_dst, wb_sel, trap_cause;
   logic       alu_src, alu_start, retire, trap;
   logic [5:0] alu_op;
   logic [2:0] state;
   outs_t      act;

   int n_chk = 0;
   int n_pass = 0;
   int start_cnt = 0;
   int retire_cnt = 0;
   int memio_cnt = 0;
   int regw_cnt = 0;
   bit trapped = 1'b0;

   always #5 clk = ~clk;

   mc_control #(
      .ALU_OP_W  (6),
      .TIMEOUT   (TIMEOUT),
      .MULDIV_EN (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .func       (func),
      .mem_ready  (mem_ready),
      .alu_done   (alu_done),
      .cond_true  (cond_true),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_byte   (mem_byte),
      .iord       (iord),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .wb_sel     (wb_sel),
      .alu_src    (alu_src),
      .alu_op     (alu_op),
      .alu_start  (alu_start),
      .retire     (retire),
      .trap       (trap),
      .trap_cause (trap_cause),
      .state      (state)
   );

   assign act = {ir_write, pc_write, pc_src, mem_req, mem_we, mem_byte, iord, reg_write,
                 reg_dst, wb_sel, alu_src, alu_op, alu_start, retire, trap, trap_cause, state};

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
   endtask

   function automatic logic rb();
      return 1'($urandom());
   endfunction

   // Reference classification straight from the MIPS opcode map
   function automatic kind_e kind_of(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00: begin
            case (fn)
               6'h20, 6'h21, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2a: return KAlu;
               6'h18, 6'h1a: return KMd;
               6'h0c:        return KSys;
               default:      return KIll;
            endcase
         end
         6'h02:                                     return KJ;
         6'h03:                                     return KJal;
         6'h01, 6'h04, 6'h05, 6'h06, 6'h07:         return KBr;
         6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f: return KImm;
         6'h20:                                     return KLb;
         6'h23:                                     return KLw;
         6'h28:                                     return KSb;
         6'h2b:                                     return KSw;
         default:                                   return KIll;
      endcase
   endfunction

   function automatic logic [5:0] ref_alu_op(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'h00:                             return fn;
         6'h09:                             return 6'b100001;
         6'h0a:                             return 6'b101010;
         6'h0c:                             return 6'b100100;
         6'h0d:                             return 6'b100101;
         6'h0e:                             return 6'b100110;
         6'h01, 6'h04, 6'h05, 6'h06, 6'h07: return 6'b100010;
         default:                           return 6'b100000;
      endcase
   endfunction

   function automatic logic ref_alu_src(input logic [5:0] op);
      return (op >= 6'h08 && op <= 6'h0f) || op == 6'h20 || op == 6'h23 || op == 6'h28 ||
             op == 6'h2b;
   endfunction

   // One cycle: entered just after a negedge, leaves just after the next one
   task automatic step(input outs_t e, input logic mr, input logic ad, input logic ct,
                       input string nm);
      mem_ready = mr;
      alu_done  = ad;
      cond_true = ct;
      #2;
      if (act.alu_start) start_cnt++;
      if (act.retire) retire_cnt++;
      if (act.reg_write) regw_cnt++;
      if (act.mem_req && act.iord) memio_cnt++;
      check(nm, {4'b0, act}, {4'b0, e});
      @(negedge clk);
   endtask

   task automatic clear_counts();
      start_cnt  = 0;
      retire_cnt = 0;
      memio_cnt  = 0;
      regw_cnt   = 0;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      alu_done  = 1'b1;
      cond_true = 1'b1;
      @(negedge clk);
      #2;
      check("reset_outputs", {4'b0, act}, 32'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      trapped = 1'b0;
   endtask

   task automatic expect_trap(input logic [1:0] cause, input string nm);
      outs_t e;
      e            = '0;
      e.trap       = 1'b1;
      e.trap_cause = cause;
      e.state      = 3'd5;
      for (int i = 0; i < 2; i++) step(e, rb(), rb(), rb(), nm);
      trapped = 1'b1;
   endtask

   // w idle cycles then mem_ready; TIMEOUT idle cycles in a row end in a timeout trap
   task automatic wait_mem(input outs_t busy, input outs_t done, input int w, input string nm,
                           output bit to);
      to = 1'b0;
      for (int i = 0; i <= w; i++) begin
         if (i == int'(TIMEOUT)) begin
            expect_trap(2'd3, {nm, "_timeout"});
            to = 1'b1;
            return;
         end
         if (i < w) step(busy, 1'b0, rb(), rb(), nm);
         else step(done, 1'b1, rb(), rb(), nm);
      end
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                            input int mw, input int aw, input logic cond, input string nm);
      outs_t      e, busy, done;
      bit         to;
      kind_e      k;
      logic       st;
      k      = kind_of(op, fn);
      st     = (k == KSw || k == KSb);
      opcode = op;
      func   = fn;

      busy         = '0;
      busy.mem_req = 1'b1;
      done         = busy;
      done.ir_write = 1'b1;
      done.pc_write = 1'b1;
      wait_mem(busy, done, fw, {nm, "_fetch"}, to);
      if (to) return;

      e       = '0;
      e.state = 3'd1;
      if (k == KIll || k == KSys) begin
         step(e, rb(), rb(), rb(), {nm, "_decode"});
         expect_trap((k == KIll) ? 2'd1 : 2'd2, {nm, "_trap"});
         return;
      end
      if (k == KJ || k == KJal) begin
         e.pc_write = 1'b1;
         e.pc_src   = 2'd2;
         e.retire   = 1'b1;
         if (k == KJal) begin
            e.reg_write = 1'b1;
            e.reg_dst   = 2'd2;
            e.wb_sel    = 2'd2;
         end
         step(e, rb(), rb(), rb(), {nm, "_jump"});
         return;
      end
      step(e, rb(), rb(), rb(), {nm, "_decode"});

      e         = '0;
      e.state   = 3'd2;
      e.alu_op  = ref_alu_op(op, fn);
      e.alu_src = ref_alu_src(op);
      if (k == KBr) begin
         e.pc_src   = 2'd1;
         e.pc_write = cond;
         e.retire   = 1'b1;
         step(e, rb(), rb(), cond, {nm, "_branch"});
         return;
      end
      if (k == KMd) begin
         for (int i = 0; i <= aw; i++) begin
            e.alu_start = (i == 0);
            e.retire    = (i == aw);
            step(e, rb(), (i == aw), rb(), {nm, "_muldiv"});
         end
         return;
      end
      step(e, rb(), rb(), rb(), {nm, "_exec"});

      if (k == KLw || k == KLb || st) begin
         busy          = e;
         busy.state    = 3'd3;
         busy.mem_req  = 1'b1;
         busy.iord     = 1'b1;
         busy.mem_we   = st;
         busy.mem_byte = (k == KLb || k == KSb);
         done          = busy;
         done.retire   = st;
         wait_mem(busy, done, mw, {nm, "_mem"}, to);
         if (to || st) return;
      end

      e.state     = 3'd4;
      e.reg_write = 1'b1;
      e.reg_dst   = (k == KAlu) ? 2'd1 : 2'd0;
      e.wb_sel    = (k == KLw || k == KLb) ? 2'd1 : 2'd0;
      e.retire    = 1'b1;
      step(e, rb(), rb(), rb(), {nm, "_wb"});
   endtask

   function automatic int pick_wait();
      if ($urandom_range(19, 0) == 0) return int'($urandom_range(18, 14));
      return int'($urandom_range(2, 0));
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[12];
      logic [11:0] pool[16];
      outs_t       e;
      int          n, rw;
      bit          fin;
      logic [1:0]  cause;

      // zero-wait latency table: cycles up to and including the retire/trap cycle
      vecs[0]  = '{6'h00, 6'h20, 1'b0, 4, 1, 2'd0};  // ADD
      vecs[1]  = '{6'h08, 6'h00, 1'b0, 4, 1, 2'd0};  // ADDI
      vecs[2]  = '{6'h23, 6'h00, 1'b0, 5, 1, 2'd0};  // LW
      vecs[3]  = '{6'h28, 6'h00, 1'b0, 4, 0, 2'd0};  // SB
      vecs[4]  = '{6'h04, 6'h00, 1'b1, 3, 0, 2'd0};  // BEQ taken
      vecs[5]  = '{6'h05, 6'h00, 1'b0, 3, 0, 2'd0};  // BNE not taken
      vecs[6]  = '{6'h00, 6'h18, 1'b0, 3, 0, 2'd0};  // MULT
      vecs[7]  = '{6'h02, 6'h00, 1'b0, 2, 0, 2'd0};  // J
      vecs[8]  = '{6'h03, 6'h00, 1'b0, 2, 1, 2'd0};  // JAL
      vecs[9]  = '{6'h0f, 6'h00, 1'b0, 4, 1, 2'd0};  // LUI
      vecs[10] = '{6'h00, 6'h0c, 1'b0, 3, 0, 2'd2};  // SYSCALL
      vecs[11] = '{6'h3f, 6'h00, 1'b0, 3, 0, 2'd1};  // illegal

      pool = '{{6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h2a}, {6'h00, 6'h25},
               {6'h00, 6'h1a}, {6'h09, 6'h00}, {6'h0c, 6'h00}, {6'h0e, 6'h00},
               {6'h23, 6'h00}, {6'h20, 6'h00}, {6'h2b, 6'h00}, {6'h28, 6'h00},
               {6'h06, 6'h00}, {6'h01, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h00}};

      do_reset();

      for (int i = 0; i < 12; i++) begin
         do_reset();
         opcode    = vecs[i].op;
         func      = vecs[i].fn;
         mem_ready = 1'b1;
         alu_done  = 1'b1;
         cond_true = vecs[i].cond;
         n = 0;
         rw = 0;
         fin = 1'b0;
         cause = 2'd0;
         while (!fin && n < 20) begin
            #2;
            n++;
            if (reg_write) rw++;
            if (retire || trap) begin
               fin   = 1'b1;
               cause = trap_cause;
            end
            @(negedge clk);
         end
         check($sformatf("tbl%0d_cycles", i), n, vecs[i].cycles);
         check($sformatf("tbl%0d_regwrites", i), rw, vecs[i].regw);
         check($sformatf("tbl%0d_cause", i), {30'b0, cause}, {30'b0, vecs[i].cause});
      end

      // directed multi-cycle corners
      do_reset();
      clear_counts();
      run_instr(6'h00, 6'h20, 0, 0, 0, 1'b0, "add");
      check("add_retires", retire_cnt, 1);
      check("add_regwrites", regw_cnt, 1);

      clear_counts();
      run_instr(6'h23, 6'h00, 0, 3, 0, 1'b0, "lw_wait3");
      check("lw_mem_iord_cycles", memio_cnt, 4);
      check("lw_retires", retire_cnt, 1);

      clear_counts();
      run_instr(6'h04, 6'h00, 1, 0, 0, 1'b1, "beq_taken");
      run_instr(6'h04, 6'h00, 0, 0, 0, 1'b0, "beq_not_taken");
      check("beq_retires", retire_cnt, 2);

      clear_counts();
      run_instr(6'h00, 6'h1a, 0, 0, 7, 1'b0, "div7");
      check("div_alu_start_pulses", start_cnt, 1);
      check("div_regwrites", regw_cnt, 0);
      check("div_retires", retire_cnt, 1);

      // last-chance mem_ready completes; one more idle cycle traps
      run_instr(6'h00, 6'h20, 15, 0, 0, 1'b0, "fetch_wait15");
      check("wait15_not_trapped", {31'b0, trapped}, 32'd0);
      run_instr(6'h2b, 6'h00, 0, 15, 0, 1'b0, "sw_wait15");
      run_instr(6'h00, 6'h20, 40, 0, 0, 1'b0, "fetch_timeout");
      check("fetch_timeout_trapped", {31'b0, trapped}, 32'd1);

      // reset while a store is completing in MEM
      do_reset();
      clear_counts();
      opcode    = 6'h2b;
      func      = 6'h00;
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2;
      check("sw_reached_mem", {29'b0, state}, 32'd3);
      mem_ready = 1'b1;
      #1;
      check("sw_retire_pending", {31'b0, retire}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("sw_abort_outputs", {4'b0, act}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      e         = '0;
      e.mem_req = 1'b1;
      step(e, 1'b0, 1'b0, 1'b0, "sw_abort_refetch");
      check("sw_abort_no_retire", retire_cnt, 0);

      // randomized instruction stream
      for (int i = 0; i < 80; i++) begin
         logic [5:0] op, fn;
         if (trapped) do_reset();
         {op, fn} = pool[$urandom_range(15, 0)];
         if ($urandom_range(9, 0) == 0) begin
            op = 6'($urandom());
            fn = 6'($urandom());
         end
         run_instr(op, fn, pick_wait(), pick_wait(), int'($urandom_range(5, 0)), rb(),
                   $sformatf("rnd%0d_op%02h_fn%02h", i, op, fn));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control sequencer for the MIPS datapath, replacing the single-cycle opcode decoder. Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, stalls on memory and multi-cycle ALU handshakes, and traps on illegal opcodes, syscall and memory timeout. Sits between the instruction register, ALU, register file, PC logic and the unified memory port.

## Interface
- ALU_OP_W, 6, width of alu_op (func-code encoding, ADD=100000, ADDU=100001, SUB=100010, AND=100100, OR=100101, XOR=100110, SLT=101010)
- TIMEOUT, 16, max cycles waiting on mem_ready before trap; 0 disables
- MULDIV_EN, 1, 1 = MULT/DIV supported; 0 = treated as illegal
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- opcode  in  6  IR[31:26], valid from DECODE onward
- func  in  6  IR[5:0]
- mem_ready  in  1  memory access completes this cycle
- alu_done  in  1  multi-cycle ALU result ready
- cond_true  in  1  branch condition for current branch opcode (datapath comparator)
- ir_write, pc_write  out  1  register load enables
- pc_src  out  2  0 PC+4, 1 branch target, 2 jump target
- mem_req, mem_we, mem_byte, iord  out  1  memory request, write, byte access, address = ALU result
- reg_write  out  1  register-file write enable
- reg_dst  out  2  0 rt, 1 rd, 2 r31
- wb_sel  out  2  0 ALU, 1 memory, 2 PC+4
- alu_src  out  1  0 rt, 1 sign-extended immediate
- alu_op  out  ALU_OP_W  ALU function
- alu_start  out  1  one-cycle pulse starting MULT/DIV
- retire  out  1  one-cycle pulse on instruction completion
- trap  out  1  sticky; trap_cause  out  2  0 none, 1 illegal, 2 syscall, 3 timeout
- state  out  3  current state, debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH: mem_req=1, iord=0. On mem_ready: ir_write=1, pc_write=1 (pc_src=0), -> DECODE.
- DECODE: latch opcode/func into class register; alu_op from latched class only after this cycle. Illegal opcode, or MULT/DIV with MULDIV_EN=0 -> TRAP cause 1; R-type func 001100 -> TRAP cause 2. J: pc_write, pc_src=2, retire, -> FETCH. JAL: same plus reg_write, reg_dst=2, wb_sel=2. Else -> EXEC.
- EXEC: alu_op/alu_src per class (R-type: func; ADDI/LW/SW/LB/SB: ADD; ADDIU: ADDU; ANDI/ORI/XORI/SLTI: AND/OR/XOR/SLT; branches: SUB; LUI: ADD with upper-immediate operand, alu_src=1). MULT/DIV: alu_start on first EXEC cycle only, hold until alu_done, then retire -> FETCH. Branch (BEQ/BNE/BLEZ/BGTZ/BGEZ): if cond_true pc_write, pc_src=1; retire -> FETCH. Loads/stores -> MEM. Others -> WB.
- MEM: mem_req=1, iord=1, mem_we for SW/SB, mem_byte for LB/SB; hold ALU controls. On mem_ready: load -> WB, store retire -> FETCH.
- WB: reg_write=1, reg_dst=1 for R-type else 0, wb_sel=1 for loads else 0; retire -> FETCH.
- TRAP: all enables 0, trap=1, trap_cause held; exit only by reset.
- Timeout: counter clears on entry to FETCH/MEM, increments each cycle mem_ready=0; reaching TIMEOUT -> TRAP cause 3. mem_ready on the same cycle as expiry wins (access completes).

## Timing
- Reset: state=FETCH, trap=0, trap_cause=0, class and counters cleared; all outputs 0 while rst_n=0. rst_n assertion mid-instruction aborts it immediately, no retire.
- Control outputs combinational from state, latched class, mem_ready, alu_done, cond_true; no input-to-state combinational loop.
- Zero-wait memory: ALU op 4 cycles, load 5, store 4, branch/MULT/DIV(alu_done at once) 3, J/JAL 2.
- mem_ready ignored outside FETCH/MEM; alu_done ignored outside MULT/DIV EXEC.

## Structure
- Package mc_pkg: state enum, opcode and func constants, pc_src/wb_sel/reg_dst/trap_cause encodings, instruction-class enum.
- Sub-module mc_decode: combinational opcode/func -> class, alu_op, alu_src, illegal/syscall flags; instantiated once.

## Test plan
- ADD (opcode 0, func 100000), mem_ready immediate -> reg_write, reg_dst=1, wb_sel=0 in cycle 4; retire once.
- LW with mem_ready delayed 3 cycles in MEM -> mem_req, iord held 4 cycles, then WB with wb_sel=1.
- BEQ cond_true=1 -> pc_write, pc_src=1 in EXEC; cond_true=0 -> no pc_write, retire still pulses.
- DIV with alu_done after 7 cycles -> alu_start exactly one pulse, no reg_write, back to FETCH.
- Opcode 111111 -> trap=1, cause=1; syscall -> cause=2; mem_ready never (TIMEOUT=16) -> cause 3 after 16 cycles.
- rst_n low during MEM of SW -> outputs 0 immediately, FETCH after release, no retire.
